// File: rtl/bsg_fakeram_1rw_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fakeram_1rw_ctrl_if
// Brief    : Request, read-return and macro-pin bundle for the fakeram controller.
// Revision : 1.0
// ============================================================================
interface bsg_fakeram_1rw_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  v_i;
    logic                  w_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      data_i;
    logic [WIDTH-1:0]      mask_i;
    logic                  ready_o;
    logic                  v_o;
    logic [WIDTH-1:0]      data_o;
    logic                  yumi_i;
    logic                  sram_ce_o;
    logic                  sram_we_o;
    logic [ADDR_WIDTH-1:0] sram_addr_o;
    logic [WIDTH-1:0]      sram_wd_o;
    logic [WIDTH-1:0]      sram_mask_o;
    logic [WIDTH-1:0]      sram_rd_i;

    // Requester plus macro side of the controller.
    modport master (
        output v_i, w_i, addr_i, data_i, mask_i, yumi_i, sram_rd_i,
        input  ready_o, v_o, data_o, sram_ce_o, sram_we_o, sram_addr_o,
               sram_wd_o, sram_mask_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, mask_i, yumi_i, sram_rd_i,
        output ready_o, v_o, data_o, sram_ce_o, sram_we_o, sram_addr_o,
               sram_wd_o, sram_mask_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_fakeram_1rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bsg_fakeram_1rw_ctrl
// Brief    : Valid/ready front end for a 1RW fakeram macro with a read-return skid FIFO.
// Revision : 1.0
// ============================================================================
module bsg_fakeram_1rw_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ELS        = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_ELS   = 2
) (
    input  wire logic             clk_i,
    input  wire logic             reset_n_i,
    bsg_fakeram_1rw_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_ELS + 1);
    localparam int PTR_W = $clog2(FIFO_ELS);
    localparam logic [CNT_W:0]   c_fifo_els = (CNT_W + 1)'(FIFO_ELS);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FIFO_ELS);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(FIFO_ELS - 1);

    generate
        if (ADDR_WIDTH != $clog2(ELS) || FIFO_ELS < 2) begin : g_param_check
            $error("bsg_fakeram_1rw_ctrl: inconsistent parameters");
        end
    endgenerate

    logic                 pend_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [WIDTH-1:0]     fifo_mem [FIFO_ELS];

    logic [CNT_W:0]       occupancy;
    logic                 ready;
    logic                 accept;
    logic                 fifo_nonempty;
    logic                 push;
    logic                 pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits cover both buffered entries and the read still in the macro.
    always_comb begin
        occupancy     = {1'b0, cnt_r} + {{CNT_W{1'b0}}, pend_r};
        ready         = reset_n_i & (occupancy < c_fifo_els);
        accept        = bus.v_i & ready;
        fifo_nonempty = (cnt_r != '0);
        pop           = reset_n_i & bus.yumi_i & fifo_nonempty;
        push          = reset_n_i & pend_r & ~(~fifo_nonempty & bus.yumi_i);
    end

    assign bus.ready_o     = ready;
    assign bus.sram_ce_o   = accept;
    assign bus.sram_we_o   = accept & bus.w_i;
    assign bus.sram_addr_o = bus.addr_i;
    assign bus.sram_wd_o   = bus.data_i;
    assign bus.sram_mask_o = bus.w_i ? bus.mask_i : '0;
    assign bus.v_o         = reset_n_i & (fifo_nonempty | pend_r);
    // Empty FIFO means the macro output is the oldest outstanding read.
    assign bus.data_o      = fifo_nonempty ? fifo_mem[rd_ptr_r] : bus.sram_rd_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pend_r   <= 1'b0;
            cnt_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            pend_r <= accept & ~bus.w_i;
            if (push) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            if (push && !pop) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            assert (!(push && !pop && cnt_r == c_cnt_full))
                else $error("bsg_fakeram_1rw_ctrl: push into full read FIFO");
            assert (!(bus.yumi_i && !bus.v_o))
                else $error("bsg_fakeram_1rw_ctrl: yumi_i without v_o");
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_r] <= bus.sram_rd_i;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bsg_fakeram_1rw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_fakeram_1rw_ctrl
// Brief    : Directed plus random bench for bsg_fakeram_1rw_ctrl with a queue-based reference.
// Revision : 1.0
// ============================================================================
module tb_bsg_fakeram_1rw_ctrl;
    localparam int WIDTH      = 32;
    localparam int ELS        = 1024;
    localparam int ADDR_WIDTH = 10;
    localparam int FIFO_ELS   = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   vectors     = 0;
    int   compares    = 0;
    int   miscompares = 0;

    bsg_fakeram_1rw_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    bsg_fakeram_1rw_ctrl #(
        .WIDTH(WIDTH), .ELS(ELS), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_ELS(FIFO_ELS)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 1RW macro driven only by the DUT pins.
    bit [WIDTH-1:0] sram_mem [ELS];
    initial bus.sram_rd_i = '0;
    always @(posedge clk) begin
        if (bus.sram_ce_o) begin
            if (bus.sram_we_o)
                sram_mem[bus.sram_addr_o] <= (sram_mem[bus.sram_addr_o] & ~bus.sram_mask_o)
                                             | (bus.sram_wd_o & bus.sram_mask_o);
            else
                bus.sram_rd_i <= sram_mem[bus.sram_addr_o];
        end
    end

    // Reference: golden memory image plus the in-order list of unreturned reads.
    bit [WIDTH-1:0] ref_mem [ELS];
    bit [WIDTH-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        compares++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic v, input logic w,
                        input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] m, input logic y);
        logic exp_ready, exp_v, acc, y_eff;
        exp_ready = rn && (exp_q.size() < FIFO_ELS);
        exp_v     = rn && (exp_q.size() > 0);
        y_eff     = y & exp_v;
        reset_n    = rn;
        bus.v_i    = v;
        bus.w_i    = w;
        bus.addr_i = a;
        bus.data_i = d;
        bus.mask_i = m;
        bus.yumi_i = y_eff;
        acc = v & exp_ready;
        @(negedge clk);
        vectors++;
        chk("ready_o", {31'b0, bus.ready_o}, {31'b0, exp_ready});
        chk("v_o", {31'b0, bus.v_o}, {31'b0, exp_v});
        if (exp_v) chk("data_o", bus.data_o, exp_q[0]);
        chk("sram_ce_o", {31'b0, bus.sram_ce_o}, {31'b0, acc});
        if (acc) begin
            chk("sram_we_o", {31'b0, bus.sram_we_o}, {31'b0, w});
            chk("sram_addr_o", {22'b0, bus.sram_addr_o}, {22'b0, a});
            chk("sram_mask_o", bus.sram_mask_o, w ? m : '0);
            if (w) chk("sram_wd_o", bus.sram_wd_o, d);
        end
        @(posedge clk);
        if (!rn) begin
            exp_q.delete();
        end else begin
            if (y_eff) void'(exp_q.pop_front());
            if (acc && w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            else if (acc) exp_q.push_back(ref_mem[a]);
        end
        #1;
    endtask

    task automatic idle(input logic y);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, y);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.v_i = 1'b0; bus.w_i = 1'b0; bus.addr_i = '0;
        bus.data_i = '0; bus.mask_i = '0; bus.yumi_i = 1'b0;

        // Reset held with a request pending: nothing may be issued.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 10'h005, '0, '0, 1'b1);
        idle(1'b0);

        // Partial-mask write then read back.
        step(1'b1, 1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF, 32'hFFFF0000, 1'b0);
        step(1'b1, 1'b1, 1'b0, 10'h3FF, '0, '0, 1'b1);
        idle(1'b1);
        chk("rd_3ff_image", ref_mem[10'h3FF], 32'hDEAD0000);

        // Preload and back-to-back reads with the consumer always ready.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 10'(i), 32'(i), '1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 10'(i), '0, '0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Stalled consumer: credits run out after two reads, then drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 10'(i + 1), '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Simultaneous push/pop at one buffered entry, pointer wrap over ten reads.
        step(1'b1, 1'b1, 1'b0, 10'd2, '0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 10'd3, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 10'(i % 8), '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset with one read buffered and one in flight.
        step(1'b1, 1'b1, 1'b0, 10'd4, '0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 10'd5, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Random traffic over a small address window to force collisions.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom),
                 10'($urandom_range(0, 15)), $urandom, $urandom,
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
